// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: steps ld -> (ark -> sub_bytes issue -> capture) x NR -> ark -> done.
// Emits datapath control strobes only; the 128-bit state never passes through here.
module aes_round_ctrl #(
  parameter int NR         = 10,
  parameter int SB_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       abort,
  output logic       ld_in,
  output logic       key_req,
  input  logic       key_valid,
  output logic [3:0] round,
  output logic       ark_en,
  output logic       sb_issue,
  output logic       sb_capture,
  output logic       mix_en,
  output logic       busy,
  output logic       done_valid,
  input  logic       done_ready
);

  localparam int CW = (SB_LATENCY > 1) ? $clog2(SB_LATENCY) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_SUB  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0]    NR_L   = 4'(NR);
  localparam logic [CW-1:0] LAT_M1 = CW'(SB_LATENCY - 1);

  logic [2:0]    state, state_nx;
  logic [3:0]    round_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          ld_raw;

  always_comb begin
    state_nx   = state;
    round_nx   = round;
    cnt_nx     = cnt;
    ld_raw     = 1'b0;
    ark_en     = 1'b0;
    sb_issue   = 1'b0;
    sb_capture = 1'b0;
    mix_en     = 1'b0;
    // abort wins over every handshake and suppresses all strobes this cycle
    if (abort) begin
      state_nx = S_IDLE;
      round_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            ld_raw   = 1'b1;
            round_nx = '0;
            state_nx = S_KEY;
          end
        end
        S_KEY: begin
          if (key_valid) begin
            ark_en = 1'b1;
            if (round == NR_L) begin
              state_nx = S_DONE;
            end else begin
              round_nx = round + 4'd1;
              state_nx = S_SUB;
            end
          end
        end
        S_SUB: begin
          sb_issue = 1'b1;
          cnt_nx   = LAT_M1;
          state_nx = S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            sb_capture = 1'b1;
            mix_en     = (round != NR_L);
            state_nx   = S_KEY;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (done_ready) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // rst gates the IDLE outputs so nothing is offered while reset is held
  assign ld_in       = ld_raw & rst;
  assign start_ready = (state == S_IDLE) & rst;
  assign key_req     = (state == S_KEY);
  assign busy        = (state != S_IDLE);
  assign done_valid  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      round <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      round <= round_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: expected strobe events queued at stimulus time, popped as the DUT emits them.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_valid, abort, key_valid, done_ready;

  logic       a_start_ready, a_ld_in, a_key_req, a_ark_en, a_sb_issue, a_sb_capture, a_mix_en, a_busy, a_done_valid;
  logic [3:0] a_round;
  logic       b_start_ready, b_ld_in, b_key_req, b_ark_en, b_sb_issue, b_sb_capture, b_mix_en, b_busy, b_done_valid;
  logic [3:0] b_round;

  aes_round_ctrl #(.NR(10), .SB_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(a_start_ready), .abort(abort),
    .ld_in(a_ld_in), .key_req(a_key_req), .key_valid(key_valid), .round(a_round), .ark_en(a_ark_en),
    .sb_issue(a_sb_issue), .sb_capture(a_sb_capture), .mix_en(a_mix_en), .busy(a_busy),
    .done_valid(a_done_valid), .done_ready(done_ready)
  );

  aes_round_ctrl #(.NR(14), .SB_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(b_start_ready), .abort(abort),
    .ld_in(b_ld_in), .key_req(b_key_req), .key_valid(key_valid), .round(b_round), .ark_en(b_ark_en),
    .sb_issue(b_sb_issue), .sb_capture(b_sb_capture), .mix_en(b_mix_en), .busy(b_busy),
    .done_valid(b_done_valid), .done_ready(done_ready)
  );

  logic sel;
  logic m_sr, m_ld, m_kr, m_ark, m_iss, m_cap, m_mix, m_busy, m_done;
  logic [3:0] m_round;
  assign m_sr    = sel ? b_start_ready : a_start_ready;
  assign m_ld    = sel ? b_ld_in       : a_ld_in;
  assign m_kr    = sel ? b_key_req     : a_key_req;
  assign m_ark   = sel ? b_ark_en      : a_ark_en;
  assign m_iss   = sel ? b_sb_issue    : a_sb_issue;
  assign m_cap   = sel ? b_sb_capture  : a_sb_capture;
  assign m_mix   = sel ? b_mix_en      : a_mix_en;
  assign m_busy  = sel ? b_busy        : a_busy;
  assign m_done  = sel ? b_done_valid  : a_done_valid;
  assign m_round = sel ? b_round       : a_round;

  typedef struct { int cyc; int kind; int rnd; logic mix; } ev_t;
  ev_t q[$];

  int total = 0, bad = 0, cyc = 0;
  logic prev_done = 1'b0;
  int sv_at, sw_from, sw_to, kv_from, kv_to, dr_from, dr_to, abort_at;
  int sr_chk, i0_chk, dw_from, dw_to, kr_from, kr_to, kr_rnd;
  int c0, c1;

  task automatic clr();
    sv_at = -1; sw_from = -1; sw_to = -1; kv_from = -1; kv_to = -1; dr_from = -1; dr_to = -1;
    abort_at = -1; sr_chk = -1; i0_chk = -1; dw_from = -1; dw_to = -1; kr_from = -1; kr_to = -1; kr_rnd = 0;
  endtask

  task automatic push(input int c, input int k, input int r, input logic m, input int cut);
    if (c < cut) q.push_back('{c, k, r, m});
  endtask

  // kinds: 0 ld_in, 1 ark_en, 2 sb_issue, 3 sb_capture, 4 done_valid rising
  task automatic push_block(input int s, input int nr, input int lat, input int sr, input int sl, input int cut);
    int t;
    push(s, 0, -1, 1'b0, cut);
    t = s + 1;
    for (int r = 0; r <= nr; r++) begin
      if (r == sr) t = t + sl;
      push(t, 1, r, 1'b0, cut);
      if (r < nr) begin
        push(t + 1, 2, r + 1, 1'b0, cut);
        push(t + 1 + lat, 3, r + 1, (r + 1 != nr), cut);
        t = t + lat + 2;
      end else begin
        push(t + 1, 4, nr, 1'b0, cut);
      end
    end
  endtask

  task automatic check_ev(input int k);
    ev_t e;
    total++;
    assert (q.size() > 0) else begin
      bad++; $error("FAIL unexpected_strobe: observed kind=%0d at cyc=%0d, expected none", k, cyc);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      assert (k === e.kind && cyc === e.cyc) else begin
        bad++; $error("FAIL event: observed kind=%0d cyc=%0d, expected kind=%0d cyc=%0d", k, cyc, e.kind, e.cyc);
      end
      if (e.rnd >= 0) begin
        total++;
        assert (int'(m_round) === e.rnd) else begin
          bad++; $error("FAIL event_round: kind=%0d cyc=%0d observed=%0d expected=%0d", k, cyc, m_round, e.rnd);
        end
      end
      if (k == 3) begin
        total++;
        assert (m_mix === e.mix) else begin
          bad++; $error("FAIL mix_en: cyc=%0d observed=%0b expected=%0b", cyc, m_mix, e.mix);
        end
      end
    end
  endtask

  task automatic drive();
    start_valid = (cyc == sv_at) || (cyc >= sw_from && cyc < sw_to);
    key_valid   = !(cyc >= kv_from && cyc < kv_to);
    done_ready  = !(cyc >= dr_from && cyc < dr_to);
    abort       = (cyc == abort_at);
  endtask

  task automatic monitor();
    int n;
    @(negedge clk);
    n = int'(m_ld) + int'(m_ark) + int'(m_iss) + int'(m_cap);
    total++;
    assert (n <= 1) else begin bad++; $error("FAIL exclusive: cyc=%0d observed=%0d strobes expected<=1", cyc, n); end
    total++;
    assert (int'(m_round) <= (sel ? 14 : 10)) else begin bad++; $error("FAIL round_max: cyc=%0d observed=%0d", cyc, m_round); end
    if (m_ld)  check_ev(0);
    if (m_ark) check_ev(1);
    if (m_iss) check_ev(2);
    if (m_cap) check_ev(3);
    if (m_done && !prev_done) check_ev(4);
    prev_done = m_done;
    if (cyc == sr_chk) begin
      total++;
      assert (m_sr === 1'b1 && m_busy === 1'b0) else begin
        bad++; $error("FAIL idle_ready: cyc=%0d observed sr=%0b busy=%0b expected 1/0", cyc, m_sr, m_busy);
      end
    end
    if (cyc == i0_chk) begin
      total++;
      assert (m_busy === 1'b0 && m_round === 4'd0 && m_sr === 1'b1) else begin
        bad++; $error("FAIL abort_idle: observed busy=%0b round=%0d sr=%0b expected 0/0/1", m_busy, m_round, m_sr);
      end
    end
    if (cyc >= dw_from && cyc < dw_to) begin
      total++;
      assert (m_done === 1'b1 && m_sr === 1'b0) else begin
        bad++; $error("FAIL done_hold: cyc=%0d observed done=%0b sr=%0b expected 1/0", cyc, m_done, m_sr);
      end
    end
    if (cyc >= kr_from && cyc < kr_to) begin
      total++;
      assert (m_kr === 1'b1 && int'(m_round) === kr_rnd) else begin
        bad++; $error("FAIL key_stall: cyc=%0d observed req=%0b round=%0d expected 1/%0d", cyc, m_kr, m_round, kr_rnd);
      end
    end
  endtask

  task automatic tick();
    drive();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic q_empty(input string tag);
    total++;
    assert (q.size() === 0) else begin bad++; $error("FAIL %s_leftover: observed=%0d expected=0", tag, q.size()); end
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    clr();
    sel = 1'b0;
    rst = 1'b0; start_valid = 1'b1; abort = 1'b0; key_valid = 1'b1; done_ready = 1'b1;
    #2;
    total++;
    assert (a_busy === 1'b0 && a_round === 4'd0 && a_done_valid === 1'b0 && a_key_req === 1'b0) else begin
      bad++; $error("FAIL reset_state: busy=%0b round=%0d done=%0b req=%0b expected 0", a_busy, a_round, a_done_valid, a_key_req);
    end
    total++;
    assert (a_ld_in === 1'b0 && a_start_ready === 1'b0 && b_ld_in === 1'b0) else begin
      bad++; $error("FAIL reset_gate: ld=%0b sr=%0b expected 0/0", a_ld_in, a_start_ready);
    end
    @(posedge clk); #1;
    start_valid = 1'b0; rst = 1'b1;
    #1;
    total++;
    assert (a_start_ready === 1'b1 && b_start_ready === 1'b1) else begin
      bad++; $error("FAIL reset_release: observed sr=%0b/%0b expected 1", a_start_ready, b_start_ready);
    end

    // 1: defaults, key_valid and done_ready high
    c0 = cyc; sv_at = c0; sr_chk = c0 + 33;
    push_block(c0, 10, 1, -1, 0, 1 << 30);
    run_to(c0 + 36);
    q_empty("t1");

    // 2: NR=14, SB_LATENCY=3
    do_reset();
    sel = 1'b1;
    c0 = cyc; sv_at = c0; sr_chk = c0 + 73;
    push_block(c0, 14, 3, -1, 0, 1 << 30);
    run_to(c0 + 76);
    q_empty("t2");
    sel = 1'b0;

    // 3: key_valid withheld 4 cycles in round 5
    do_reset();
    c0 = cyc; sv_at = c0; kv_from = c0 + 16; kv_to = c0 + 20;
    kr_from = c0 + 16; kr_to = c0 + 20; kr_rnd = 5; sr_chk = c0 + 37;
    push_block(c0, 10, 1, 5, 4, 1 << 30);
    run_to(c0 + 40);
    q_empty("t3");

    // 4: done_ready low for 6 cycles while start_valid is offered
    do_reset();
    c0 = cyc; sv_at = c0; dr_from = c0 + 32; dr_to = c0 + 38;
    sw_from = c0 + 32; sw_to = c0 + 38; dw_from = c0 + 32; dw_to = c0 + 39; sr_chk = c0 + 39;
    push_block(c0, 10, 1, -1, 0, 1 << 30);
    run_to(c0 + 41);
    q_empty("t4");

    // 5: abort in WAIT of round 3 with key_valid high, then a clean block
    do_reset();
    c0 = cyc; sv_at = c0; abort_at = c0 + 9; i0_chk = c0 + 10;
    push_block(c0, 10, 1, -1, 0, c0 + 9);
    run_to(c0 + 11);
    q_empty("t5a");
    c1 = cyc; sv_at = c1; sr_chk = c1 + 33;
    push_block(c1, 10, 1, -1, 0, 1 << 30);
    run_to(c1 + 35);
    q_empty("t5b");

    // 6: asynchronous reset while stalled in KEY of round 7
    do_reset();
    c0 = cyc; sv_at = c0; kv_from = c0 + 22; kv_to = c0 + 60;
    kr_from = c0 + 22; kr_to = c0 + 24; kr_rnd = 7;
    push_block(c0, 10, 1, -1, 0, c0 + 22);
    run_to(c0 + 24);
    #2; rst = 1'b0; #1;
    total++;
    assert (a_busy === 1'b0 && a_key_req === 1'b0 && a_round === 4'd0 && a_done_valid === 1'b0) else begin
      bad++; $error("FAIL async_reset: busy=%0b req=%0b round=%0d done=%0b expected 0", a_busy, a_key_req, a_round, a_done_valid);
    end
    q_empty("t6a");
    clr();
    tick(); tick();
    rst = 1'b1;
    #1;
    total++;
    assert (a_start_ready === 1'b1) else begin bad++; $error("FAIL async_release: observed sr=%0b expected 1", a_start_ready); end
    c0 = cyc; sv_at = c0; sr_chk = c0 + 33;
    push_block(c0, 10, 1, -1, 0, 1 << 30);
    run_to(c0 + 35);
    q_empty("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES encryption round sequencer; drives the shared `sub_bytes` stage, the key-schedule handshake and the round datapath enables.
- Sits between the block-level start/done handshake and the AES round datapath: add_round_key, `sub_bytes`, shift_rows, mix_columns and the state register.
- Emits control strobes only; never touches the 128-bit data itself.

Parameters:
- NR, 10: number of rounds; legal values 10, 12, 14.
- SB_LATENCY, 1: `sub_bytes` latency in clock cycles, from data_in registered to data_out valid; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start_valid  input  1  new block is present on the datapath input
- start_ready  output  1  controller can accept a block
- abort  input  1  synchronous cancel of the current block
- ld_in  output  1  pulse: datapath state register loads the plaintext
- key_req  output  1  request for the round key selected by `round`
- key_valid  input  1  round key for `round` is present
- round  output  4  current round index, 0..NR
- ark_en  output  1  pulse: state <= state XOR round key
- sb_issue  output  1  pulse: state is presented to `sub_bytes` this cycle
- sb_capture  output  1  pulse: `sub_bytes` output valid; state <= shift/mix result
- mix_en  output  1  mix_columns enabled in the sb_capture cycle
- busy  output  1  controller is in any state other than IDLE
- done_valid  output  1  ciphertext is in the state register
- done_ready  input  1  consumer accepts the ciphertext

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE and round=0.
  - All pulses, key_req, busy and done_valid go to 0.
  - start_ready goes to 1 once rst is released.
- States: IDLE, KEY, SUB, WAIT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid in this state: ld_in=1 in that cycle, round<=0, next state KEY.
- KEY:
  - key_req=1 for as long as the controller waits; key_valid may take any number of cycles.
  - ark_en=1 (Mealy) in the cycle key_valid=1.
  - Same cycle: if round==NR, go to DONE; otherwise round<=round+1 and go to SUB.
- SUB:
  - sb_issue=1 for exactly one cycle.
  - Latency counter loads SB_LATENCY-1; next state WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter equals 0: sb_capture=1 and mix_en=(round!=NR); next state KEY.
  - WAIT therefore lasts exactly SB_LATENCY cycles.
- DONE:
  - done_valid=1, held stable until done_ready=1.
  - On handshake go to IDLE. The next start is accepted no earlier than the following cycle, since start_ready=0 in DONE.
- Timing with key_valid tied high:
  - Accept cycle is C0; round-0 ark_en at C1.
  - Round r ark_en at C1 + r*(SB_LATENCY+2).
  - done_valid first asserts at C2 + NR*(SB_LATENCY+2).
  - With defaults: ark_en for round 10 at C31, done_valid at C32.
- Strobe exclusivity: ld_in, ark_en, sb_issue and sb_capture are mutually exclusive. At most one is high in any cycle.
- round is held constant through SUB and WAIT, and is never greater than NR.
- abort=1, any state: next state IDLE, round<=0, no strobes in the abort cycle.
  - Abort takes priority over key_valid, the capture cycle and the done handshake.
  - abort in IDLE overrides start_valid: the block is not accepted and ld_in=0.
- key_valid is ignored outside KEY; done_ready is ignored outside DONE.
- rst asserted mid-block: immediate return to IDLE. No partial-completion indication.

Test Plan:
1. Defaults, key_valid=1 and done_ready=1 tied high; start_valid pulsed at C0.
   - ld_in at C0.
   - ark_en at C1, C4, ..., C31, with round 0..10.
   - sb_issue at C2+3k and sb_capture at C3+3k.
   - mix_en=1 on the first 9 captures and 0 on the 10th.
   - done_valid at C32; start_ready=1 at C33.
2. NR=14, SB_LATENCY=3.
   - Gap from sb_issue to sb_capture is 3 cycles.
   - 14 captures in total; done_valid at C2+14*5 = C72.
3. key_valid withheld for 4 cycles in round 5.
   - key_req and round=5 held steady; no ark_en during the stall.
   - done_valid delayed by exactly 4 cycles versus case 1.
4. done_ready held 0 for 6 cycles.
   - done_valid stays 1 and start_valid is refused (start_ready=0).
   - Return to IDLE the cycle after done_ready=1.
5. abort pulsed in WAIT during round 3, key_valid=1 in the same cycle.
   - No sb_capture in that cycle.
   - IDLE next cycle with round=0; a new start completes normally, as in case 1.
6. rst asserted asynchronously mid-KEY in round 7.
   - Outputs clear immediately without waiting for a clock edge.
   - After release, start_ready=1 and a full block completes with correct strobe timing.
